fifo_bank: RTL and testbench
============================

FIFO_BANK -- requirements
Module: fifo_bank

Interface
REQ-001 SHALL have parameter SIZE, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, per-channel address bits; each channel holds 2^DEPTH words.
REQ-003 SHALL have parameter CHANNELS, default 4, number of independent queues (2..16).
REQ-004 SHALL have parameter AFULL_LEVEL, default 2^DEPTH-1, occupancy at which almost_full asserts.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port write_enable  input  1  push data_in into write_channel.
REQ-008 SHALL have port write_channel  input  CH_W=$clog2(CHANNELS)  target queue of push.
REQ-009 SHALL have port data_in  input  SIZE  push data.
REQ-010 SHALL have port read_update  input  1  pop head of read_channel.
REQ-011 SHALL have port read_channel  input  CH_W  source queue of pop.
REQ-012 SHALL have port data_out  output  SIZE  registered popped word.
REQ-013 SHALL have port data_valid  output  1  data_out updated this cycle.
REQ-014 SHALL have ports empty, full, almost_full  output  CHANNELS  per-channel status, bit i = channel i.
REQ-015 SHALL have port level  output  CHANNELS*(DEPTH+1)  per-channel occupancy, channel i at bits [i*(DEPTH+1) +: DEPTH+1].

Function
REQ-016 SHALL store all channels in one shared memory, address {channel, pointer}, one write port, one read port.
REQ-017 SHALL keep per channel a DEPTH-bit write pointer, DEPTH-bit read pointer and (DEPTH+1)-bit count; pointers wrap 2^DEPTH-1 -> 0.
REQ-018 SHALL accept a push when write_enable=1 and the target is not full, or is full with a same-cycle accepted pop on the same channel.
REQ-019 SHALL accept a pop when read_update=1 and read_channel is not empty; a push to an empty channel in the same cycle SHALL NOT be bypassed (pop ignored).
REQ-020 SHALL drop rejected pushes/pops with no change to memory, pointers, count, data_out.
REQ-021 SHALL present the popped word on data_out and pulse data_valid exactly one cycle after an accepted pop; data_out holds otherwise.
REQ-022 SHALL update count: +1 push only, -1 pop only, unchanged for push+pop same channel or different-channel events applied independently.
REQ-023 SHALL derive empty = (count==0), full = (count==2^DEPTH), almost_full = (count>=AFULL_LEVEL), all from registered count, no combinational path from inputs.
REQ-024 SHALL allow push and pop on different channels in the same cycle at full throughput.

Reset
REQ-025 SHALL on reset low asynchronously clear all pointers and counts, data_out=0, data_valid=0, empty=all ones, full=0, almost_full=0 (unless AFULL_LEVEL=0), level=0.
REQ-026 SHALL discard in-flight pops on reset assertion mid-operation; memory contents need not be cleared.

Configuration
REQ-027 SHALL with macro FIFO_BANK_ERR_EN defined add outputs overflow and underflow (CHANNELS each), sticky bit set on rejected push/pop per channel, cleared only by reset.
REQ-028 SHALL without FIFO_BANK_ERR_EN omit those ports and flops entirely; all other behaviour identical.

Structure
REQ-029 SHALL place in package fifo_bank_pkg: channel-width helper function, MAX_CHANNELS=16 constant, status struct {empty, full, almost_full, count}.
REQ-030 SHALL implement per-channel pointer/count logic in sub-module fifo_bank_chan, instantiated CHANNELS times via generate.

Verification (SIZE=8, DEPTH=2, CHANNELS=4, AFULL_LEVEL=3)
REQ-031 SHALL push 0x11,0x22,0x33,0x44 to ch2 -> full[2]=1, almost_full[2]=1 after 3rd push, level ch2=4; 4 pops return same order, data_valid one cycle after each pop.
REQ-032 SHALL push 0x55 to full ch2 without pop -> dropped, level stays 4, overflow[2]=1 when FIFO_BANK_ERR_EN.
REQ-033 SHALL push+pop ch2 same cycle while full -> level stays 4, data_out=head, new word at tail; on empty ch1 same cycle -> level ch1=1, no data_valid.
REQ-034 SHALL push 0xA0 to ch0 while popping ch3 same cycle -> both accepted, channels independent, other levels unchanged.
REQ-035 SHALL assert reset low mid-stream with ch0 level=3 -> immediately empty=4'b1111, level=0, data_valid=0; next push/pop pair returns the new word.
REQ-036 SHALL pop empty ch1 -> no data_valid, data_out unchanged, underflow[1]=1 when FIFO_BANK_ERR_EN.

Source files
------------

// File: rtl/fifo_bank_pkg.sv
// fifo_bank_pkg -- shared definitions for the fifo_bank multi-channel queue.
//   ch_width()     : width of a channel-select field for a given channel count
//   MAX_CHANNELS   : largest supported channel count
//   MAX_LEVEL_W    : width of the occupancy field carried in the status struct
//   chan_status_t  : per-channel status {empty, full, almost_full, count}
package fifo_bank_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MAX_LEVEL_W  = 17;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                   empty;
        logic                   full;
        logic                   almost_full;
        logic [MAX_LEVEL_W-1:0] count;
    } chan_status_t;

endpackage

// File: rtl/fifo_bank_chan.sv
// fifo_bank_chan -- pointer/occupancy bookkeeping for one fifo_bank queue.
// Decides whether this channel's push/pop request is accepted and keeps the
// write pointer, read pointer and count. Storage lives in the parent.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   push_req, pop_req    : request addressed to this channel
//   push_ok, pop_ok      : request accepted this cycle
//   wr_ptr, rd_ptr       : current tail / head slot
//   status               : registered empty/full/almost_full/count
//   overflow, underflow  : sticky rejected-push/pop flags (FIFO_BANK_ERR_EN only)
module fifo_bank_chan
    import fifo_bank_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = (1 << DEPTH) - 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [DEPTH-1:0] wr_ptr,
    output logic [DEPTH-1:0] rd_ptr,
    output chan_status_t     status
`ifdef FIFO_BANK_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [DEPTH:0] FULL_CNT  = (DEPTH+1)'(1 << DEPTH);
    localparam logic [DEPTH:0] AFULL_CNT = (DEPTH+1)'(AFULL_LEVEL);

    logic [DEPTH:0] count;

    // A pop on an empty channel is never bypassed from a same-cycle push.
    // A push into a full channel is fine when a pop frees the head slot.
    assign pop_ok  = pop_req && (count != '0);
    assign push_ok = push_req && ((count != FULL_CNT) || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign status.empty       = (count == '0);
    assign status.full        = (count == FULL_CNT);
    assign status.almost_full = (count >= AFULL_CNT);
    assign status.count       = MAX_LEVEL_W'(count);

`ifdef FIFO_BANK_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_req && !push_ok)
                overflow <= 1'b1;
            if (pop_req && !pop_ok)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fifo_bank.sv
// fifo_bank -- CHANNELS independent FIFOs sharing one memory, addressed as
// {channel, pointer}. One push and one pop per cycle, on any channels.
// Optional build macro: FIFO_BANK_ERR_EN adds sticky overflow/underflow flags.
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   write_enable, write_channel, data_in : push request
//   read_update, read_channel          : pop request
//   data_out, data_valid               : popped word, valid one cycle after pop
//   empty, full, almost_full           : per-channel status bits
//   level                              : per-channel occupancy, DEPTH+1 bits each
//   overflow, underflow                : per-channel sticky errors (macro only)
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int SIZE        = 16,
    parameter int DEPTH       = 4,
    parameter int CHANNELS    = 4,
    parameter int AFULL_LEVEL = (1 << DEPTH) - 1,
    localparam int CH_W       = ch_width(CHANNELS)
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write_enable,
    input  logic [CH_W-1:0]                write_channel,
    input  logic [SIZE-1:0]                data_in,
    input  logic                           read_update,
    input  logic [CH_W-1:0]                read_channel,
    output logic [SIZE-1:0]                data_out,
    output logic                           data_valid,
    output logic [CHANNELS-1:0]            empty,
    output logic [CHANNELS-1:0]            full,
    output logic [CHANNELS-1:0]            almost_full,
    output logic [CHANNELS*(DEPTH+1)-1:0]  level
`ifdef FIFO_BANK_ERR_EN
    ,
    output logic [CHANNELS-1:0]            overflow,
    output logic [CHANNELS-1:0]            underflow
`endif
);

    // Channel slots are padded to a power of two so any select value indexes
    // a defined entry; padding slots never accept anything.
    localparam int SLOTS = 1 << CH_W;
    localparam int AW    = CH_W + DEPTH;

    logic [SIZE-1:0]  mem [1 << AW];
    logic [DEPTH-1:0] wr_ptr [SLOTS];
    logic [DEPTH-1:0] rd_ptr [SLOTS];
    logic [SLOTS-1:0] push_ok;
    logic [SLOTS-1:0] pop_ok;
    logic             push_acc;
    logic             pop_acc;
    logic [SIZE-1:0]  rd_data_p1;
    logic             vld_p1;

    for (genvar i = 0; i < SLOTS; i++) begin : g_chan
        if (i < CHANNELS) begin : g_used
            chan_status_t st;

            fifo_bank_chan #(
                .DEPTH       (DEPTH),
                .AFULL_LEVEL (AFULL_LEVEL)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .push_req  (write_enable && (write_channel == CH_W'(i))),
                .pop_req   (read_update && (read_channel == CH_W'(i))),
                .push_ok   (push_ok[i]),
                .pop_ok    (pop_ok[i]),
                .wr_ptr    (wr_ptr[i]),
                .rd_ptr    (rd_ptr[i]),
                .status    (st)
`ifdef FIFO_BANK_ERR_EN
                ,
                .overflow  (overflow[i]),
                .underflow (underflow[i])
`endif
            );

            assign empty[i]                       = st.empty;
            assign full[i]                        = st.full;
            assign almost_full[i]                 = st.almost_full;
            assign level[i*(DEPTH+1) +: DEPTH+1]  = st.count[DEPTH:0];
        end else begin : g_pad
            assign push_ok[i] = 1'b0;
            assign pop_ok[i]  = 1'b0;
            assign wr_ptr[i]  = '0;
            assign rd_ptr[i]  = '0;
        end
    end

    assign push_acc = |push_ok;
    assign pop_acc  = |pop_ok;

    // Stage p0 -> memory write; a same-address read this cycle sees the old word
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[{write_channel, wr_ptr[write_channel]}] <= data_in;
    end

    // Stage p0 -> p1: popped word registered, valid alongside
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= pop_acc;
            if (pop_acc)
                rd_data_p1 <= mem[{read_channel, rd_ptr[read_channel]}];
        end
    end

    assign data_out   = rd_data_p1;
    assign data_valid = vld_p1;

endmodule

// File: tb/tb_fifo_bank.sv
// tb_fifo_bank -- directed bench for fifo_bank (SIZE=8, DEPTH=2, CHANNELS=4,
// AFULL_LEVEL=3). A vector table covers push/pop/full/simultaneous cases;
// hand-written sequences cover reset states and mid-stream async reset.
module tb_fifo_bank;

    logic        clk;
    logic        reset;
    logic        write_enable;
    logic [1:0]  write_channel;
    logic [7:0]  data_in;
    logic        read_update;
    logic [1:0]  read_channel;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  almost_full;
    logic [11:0] level;
`ifdef FIFO_BANK_ERR_EN
    logic [3:0]  overflow;
    logic [3:0]  underflow;
`endif

    int checks;
    int errors;

    fifo_bank #(
        .SIZE        (8),
        .DEPTH       (2),
        .CHANNELS    (4),
        .AFULL_LEVEL (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_channel (write_channel),
        .data_in       (data_in),
        .read_update   (read_update),
        .read_channel  (read_channel),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .level         (level)
`ifdef FIFO_BANK_ERR_EN
        ,
        .overflow      (overflow),
        .underflow     (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  wch;
        logic [7:0]  din;
        logic        ru;
        logic [1:0]  rch;
        logic        dv;
        logic [7:0]  dout;
        logic [3:0]  emp;
        logic [3:0]  ful;
        logic [3:0]  af;
        logic [11:0] lvl;
    } vec_t;

    vec_t vec [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] wch, input logic [7:0] din,
                         input logic ru, input logic [1:0] rch);
        @(negedge clk);
        write_enable  = we;
        write_channel = wch;
        data_in       = din;
        read_update   = ru;
        read_channel  = rch;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // level packing: ch0 [2:0], ch1 [5:3], ch2 [8:6], ch3 [11:9]
        //                we    wch   din    ru    rch  | dv    dout   emp      ful      af       lvl
        vec[0]  = '{1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1011, 4'b0000, 4'b0000, 12'h040};
        vec[1]  = '{1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1011, 4'b0000, 4'b0000, 12'h080};
        vec[2]  = '{1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1011, 4'b0000, 4'b0100, 12'h0C0};
        vec[3]  = '{1'b1, 2'd2, 8'h44, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1011, 4'b0100, 4'b0100, 12'h100};
        vec[4]  = '{1'b1, 2'd2, 8'h55, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1011, 4'b0100, 4'b0100, 12'h100};
        vec[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h11, 4'b1011, 4'b0000, 4'b0100, 12'h0C0};
        vec[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h22, 4'b1011, 4'b0000, 4'b0000, 12'h080};
        vec[7]  = '{1'b1, 2'd2, 8'h55, 1'b0, 2'd0, 1'b0, 8'h22, 4'b1011, 4'b0000, 4'b0100, 12'h0C0};
        vec[8]  = '{1'b1, 2'd2, 8'h66, 1'b0, 2'd0, 1'b0, 8'h22, 4'b1011, 4'b0100, 4'b0100, 12'h100};
        vec[9]  = '{1'b1, 2'd2, 8'h77, 1'b1, 2'd2, 1'b1, 8'h33, 4'b1011, 4'b0100, 4'b0100, 12'h100};
        vec[10] = '{1'b1, 2'd1, 8'h88, 1'b1, 2'd1, 1'b0, 8'h33, 4'b1001, 4'b0100, 4'b0100, 12'h108};
        vec[11] = '{1'b1, 2'd3, 8'hB1, 1'b0, 2'd0, 1'b0, 8'h33, 4'b0001, 4'b0100, 4'b0100, 12'h308};
        vec[12] = '{1'b1, 2'd0, 8'hA0, 1'b1, 2'd3, 1'b1, 8'hB1, 4'b1000, 4'b0100, 4'b0100, 12'h109};
        vec[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h88, 4'b1010, 4'b0100, 4'b0100, 12'h101};
        vec[14] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 8'h88, 4'b1010, 4'b0100, 4'b0100, 12'h101};
        vec[15] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h44, 4'b1010, 4'b0000, 4'b0100, 12'h0C1};
        vec[16] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h55, 4'b1010, 4'b0000, 4'b0000, 12'h081};
        vec[17] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h66, 4'b1010, 4'b0000, 4'b0000, 12'h041};
        vec[18] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h77, 4'b1110, 4'b0000, 4'b0000, 12'h001};
        vec[19] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h77, 4'b1110, 4'b0000, 4'b0000, 12'h001};

        write_enable  = 1'b0;
        write_channel = 2'd0;
        data_in       = 8'h00;
        read_update   = 1'b0;
        read_channel  = 2'd0;
        reset         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty), 32'hF);
        check("rst_full", 32'(full), 32'h0);
        check("rst_afull", 32'(almost_full), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_dout", 32'(data_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vec[i].we, vec[i].wch, vec[i].din, vec[i].ru, vec[i].rch);
            check($sformatf("v%0d_dv", i), 32'(data_valid), 32'(vec[i].dv));
            check($sformatf("v%0d_dout", i), 32'(data_out), 32'(vec[i].dout));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vec[i].emp));
            check($sformatf("v%0d_full", i), 32'(full), 32'(vec[i].ful));
            check($sformatf("v%0d_afull", i), 32'(almost_full), 32'(vec[i].af));
            check($sformatf("v%0d_level", i), 32'(level), 32'(vec[i].lvl));
        end

`ifdef FIFO_BANK_ERR_EN
        check("err_overflow", 32'(overflow), 32'h4);
        check("err_underflow", 32'(underflow), 32'h2);
`endif

        // Fill ch0 to level 3 (A0 already queued), then reset with a pop in flight
        drive(1'b1, 2'd0, 8'hC1, 1'b0, 2'd0);
        drive(1'b1, 2'd0, 8'hC2, 1'b0, 2'd0);
        check("pre_rst_level", 32'(level), 32'h003);
        @(negedge clk);
        write_enable = 1'b0;
        read_update  = 1'b1;
        read_channel = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 32'hF);
        check("arst_level", 32'(level), 32'h0);
        check("arst_dv", 32'(data_valid), 32'h0);
        check("arst_dout", 32'(data_out), 32'h0);
        check("arst_full", 32'(full), 32'h0);
`ifdef FIFO_BANK_ERR_EN
        check("arst_overflow", 32'(overflow), 32'h0);
        check("arst_underflow", 32'(underflow), 32'h0);
`endif
        @(posedge clk);
        #1;
        check("arst_hold_dv", 32'(data_valid), 32'h0);
        check("arst_hold_level", 32'(level), 32'h0);
        @(negedge clk);
        read_update = 1'b0;
        reset       = 1'b1;

        drive(1'b1, 2'd0, 8'hC3, 1'b0, 2'd0);
        check("post_rst_push_level", 32'(level), 32'h001);
        check("post_rst_push_dv", 32'(data_valid), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        check("post_rst_pop_dv", 32'(data_valid), 32'h1);
        check("post_rst_pop_dout", 32'(data_out), 32'hC3);
        check("post_rst_pop_empty", 32'(empty), 32'hF);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        check("post_rst_idle_dv", 32'(data_valid), 32'h0);
        check("post_rst_idle_dout", 32'(data_out), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
